// File: rtl/regbank_rr_arbiter.sv
// regbank_rr_arbiter: round-robin write arbiter in front of a small register bank.
// NREQ requesters compete for one write port; at most one write commits per
// cycle, and the winner sees a registered one-cycle grant in the same cycle its
// write shows up on regs_q.
// Optional feature: define REGARB_LOCK_EN to add the lock input, which lets the
// current grant holder keep ownership for back-to-back writes.
module regbank_rr_arbiter #(
    parameter int NREQ = 3,
    parameter int NREG = 3,
    parameter int W    = 8,
    parameter int AW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*W-1:0]    wdata,
`ifdef REGARB_LOCK_EN
    input  logic [NREQ-1:0]      lock,
`endif
    output logic [NREQ-1:0]      gnt,
    output logic                 err,
    output logic                 busy,
    output logic [NREG*W-1:0]    regs_q
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

    logic [NREQ-1:0]          r_gnt;
    logic                     r_err;
    logic                     r_busy;
    logic [PW-1:0]            r_ptr;
    logic [NREG-1:0][W-1:0]   r_regs;

    logic [NREQ-1:0]          w_elig;
    logic                     w_found;
    logic [PW-1:0]            w_win;
    logic [AW-1:0]            w_addr;
    logic [W-1:0]             w_data;
    logic                     w_addr_ok;
    int                       w_best;
    int                       w_dist;

    // Eligibility: last cycle's winner sits out one cycle, unless it holds the lock.
`ifdef REGARB_LOCK_EN
    logic w_own;
    always_comb begin
        w_own  = |(r_gnt & lock & req);
        w_elig = w_own ? (req & r_gnt) : (req & ~r_gnt);
    end
`else
    always_comb begin
        w_elig = req & ~r_gnt;
    end
`endif

    // Winner = eligible requester at the smallest circular distance from ptr;
    // its address and data are muxed out alongside.
    always_comb begin
        w_best = NREQ;
        w_dist = 0;
        w_win  = '0;
        w_addr = '0;
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = (i + NREQ - int'(r_ptr)) % NREQ;
            if (w_elig[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_win  = PW'(i);
                w_addr = addr[i*AW +: AW];
                w_data = wdata[i*W +: W];
            end
        end
        w_found   = (w_best < NREQ);
        w_addr_ok = (int'(w_addr) < NREG);
    end

    // Grant, status and round-robin pointer; pointer moves just past the winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt  <= '0;
            r_err  <= 1'b0;
            r_busy <= 1'b0;
            r_ptr  <= '0;
        end else if (w_found) begin
            for (int i = 0; i < NREQ; i++) begin
                r_gnt[i] <= (PW'(i) == w_win);
            end
            r_busy <= 1'b1;
            r_err  <= ~w_addr_ok;
            r_ptr  <= (w_win == LAST) ? '0 : w_win + 1'b1;
        end else begin
            r_gnt  <= '0;
            r_busy <= 1'b0;
            r_err  <= 1'b0;
        end
    end

    // Register bank: granted in-range write commits on the same edge as its grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_regs <= '0;
        end else if (w_found && w_addr_ok) begin
            for (int j = 0; j < NREG; j++) begin
                if (int'(w_addr) == j) begin
                    r_regs[j] <= w_data;
                end
            end
        end
    end

    assign gnt    = r_gnt;
    assign err    = r_err;
    assign busy   = r_busy;
    assign regs_q = r_regs;

endmodule

// File: tb/tb_regbank_rr_arbiter.sv
// Bench for regbank_rr_arbiter: directed scenarios followed by randomized
// requesters. A reference model predicts each edge's outputs into a queue; a
// monitor pops and compares one entry after every rising edge.
module tb_regbank_rr_arbiter;
    localparam int NREQ = 3;
    localparam int NREG = 3;
    localparam int W    = 8;
    localparam int AW   = 2;

    typedef struct {
        logic [NREQ-1:0]   gnt;
        logic              err;
        logic              busy;
        logic [NREG*W-1:0] regs;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*AW-1:0]  addr = '0;
    logic [NREQ*W-1:0]   wdata = '0;
    logic [NREQ-1:0]     gnt;
    logic                err;
    logic                busy;
    logic [NREG*W-1:0]   regs_q;
`ifdef REGARB_LOCK_EN
    logic [NREQ-1:0]     lock = '0;
`endif

    regbank_rr_arbiter #(.NREQ(NREQ), .NREG(NREG), .W(W), .AW(AW)) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .wdata(wdata),
`ifdef REGARB_LOCK_EN
        .lock(lock),
`endif
        .gnt(gnt), .err(err), .busy(busy), .regs_q(regs_q)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic [W-1:0] mregs [NREG];
    int           mptr  = 0;
    int           mlast = -1;

    // Randomized requester state
    bit           have [NREQ];
    logic [AW-1:0] ra  [NREQ];
    logic [W-1:0]  rd  [NREQ];

    // One cycle: drive inputs at negedge, predict the outputs after the next edge.
    task automatic step(input logic r, input logic [NREQ-1:0] rq,
                        input logic [NREQ*AW-1:0] av, input logic [NREQ*W-1:0] dv);
        exp_t e;
        int   win;
        int   a;
        @(negedge clk);
        rst = r; req = rq; addr = av; wdata = dv;
        e.gnt = '0; e.err = 1'b0; e.busy = 1'b0;
        if (r) begin
            for (int j = 0; j < NREG; j++) mregs[j] = '0;
            mptr = 0; mlast = -1;
        end else begin
            win = -1;
            for (int s = 0; s < NREQ; s++) begin
                int idx;
                idx = (mptr + s) % NREQ;
                if (win < 0 && rq[idx] && idx != mlast) win = idx;
            end
            if (win >= 0) begin
                e.gnt[win] = 1'b1;
                e.busy = 1'b1;
                mptr = (win + 1) % NREQ;
                a = int'(av[win*AW +: AW]);
                if (a < NREG) mregs[a] = dv[win*W +: W];
                else e.err = 1'b1;
            end
            mlast = win;
        end
        for (int j = 0; j < NREG; j++) e.regs[j*W +: W] = mregs[j];
        q.push_back(e);
    endtask

    // Monitor: one expected entry per edge once stimulus has begun.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks += 4;
            if (gnt !== e.gnt) begin
                errors++; $display("FAIL gnt: got %b want %b at %0t", gnt, e.gnt, $time);
            end
            if (err !== e.err) begin
                errors++; $display("FAIL err: got %b want %b at %0t", err, e.err, $time);
            end
            if (busy !== e.busy) begin
                errors++; $display("FAIL busy: got %b want %b at %0t", busy, e.busy, $time);
            end
            if (regs_q !== e.regs) begin
                errors++; $display("FAIL regs_q: got %h want %h at %0t", regs_q, e.regs, $time);
            end
        end
    end

    initial begin
        logic [NREQ-1:0]    rq;
        logic [NREQ*AW-1:0] av;
        logic [NREQ*W-1:0]  dv;
        logic               r;

        // Reset, then preload every register with 0xFF via rotation.
        step(1'b1, 3'b000, '0, '0);
        step(1'b1, 3'b000, '0, '0);
        for (int k = 0; k < 3; k++) step(1'b0, 3'b111, {2'd2, 2'd1, 2'd0}, 24'hFFFFFF);
        // Reset beats a simultaneous request from everyone.
        step(1'b1, 3'b111, {2'd2, 2'd1, 2'd0}, 24'h123456);
        // Single writer: grant, skip, grant.
        step(1'b0, 3'b010, {2'd0, 2'd2, 2'd0}, 24'h00A500);
        step(1'b0, 3'b010, {2'd0, 2'd2, 2'd0}, 24'h00A500);
        step(1'b0, 3'b010, {2'd0, 2'd2, 2'd0}, 24'h00A500);
        step(1'b0, 3'b000, '0, '0);
        // Rotation from a fresh pointer.
        step(1'b1, 3'b000, '0, '0);
        for (int k = 0; k < 4; k++) step(1'b0, 3'b111, {2'd2, 2'd1, 2'd0}, 24'h332211);
        // Same address from requesters 0 and 2.
        step(1'b1, 3'b000, '0, '0);
        step(1'b0, 3'b101, {2'd1, 2'd0, 2'd1}, 24'h200010);
        step(1'b0, 3'b100, {2'd1, 2'd0, 2'd1}, 24'h200010);
        step(1'b0, 3'b000, '0, '0);
        // Out-of-range address.
        step(1'b0, 3'b001, {2'd0, 2'd0, 2'd3}, 24'h0000EE);
        step(1'b0, 3'b000, '0, '0);

        // Randomized requesters following the hold-until-granted handshake.
        for (int i = 0; i < NREQ; i++) begin have[i] = 0; ra[i] = '0; rd[i] = '0; end
        for (int c = 0; c < 600; c++) begin
            r = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (i == mlast) begin
                    have[i] = ($urandom_range(0, 1) == 1);
                    ra[i] = AW'($urandom_range(0, 3));
                    rd[i] = W'($urandom);
                end else if (!have[i] && $urandom_range(0, 1) == 1) begin
                    have[i] = 1;
                    ra[i] = AW'($urandom_range(0, 3));
                    rd[i] = W'($urandom);
                end
                rq[i] = have[i];
                av[i*AW +: AW] = ra[i];
                dv[i*W +: W] = rd[i];
            end
            step(r, rq, av, dv);
            if (r) for (int i = 0; i < NREQ; i++) have[i] = 0;
        end
        step(1'b0, 3'b000, '0, '0);

        @(posedge clk); #2;
        checks++;
        if (q.size() != 0) begin
            errors++; $display("FAIL queue_drain: got %0d want 0 pending", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
